// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write to DMA_REG_ADDR halts the CPU and copies 256 bytes
// from page {page,00..FF} into the PPU OAM data register. Optional macro: OAM_DMA_ODD_ALIGN_EN.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic [7:0]  bus_rdata,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        cpu_halt,
    output logic        dma_busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  data_q, data_d;
    logic        parity_q, parity_d;
    logic        halt_q, halt_d;
    logic        busy_q, busy_d;
    logic        trigger_s;

    function automatic logic next_parity(input logic cur);
        next_parity = ~cur;
    endfunction

    assign trigger_s = cpu_we && (cpu_addr == DMA_REG_ADDR);

    // Next-state and datapath computation
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        index_d  = index_q;
        data_d   = data_q;
        parity_d = next_parity(parity_q);
        case (state_q)
            IDLE: begin
                if (trigger_s) begin
                    page_d  = cpu_wdata;
                    index_d = 8'h00;
                    state_d = HALT;
                end else begin
                    state_d = IDLE;
                end
            end
            HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
                if (parity_q) begin
                    state_d = ALIGN;
                end else begin
                    state_d = READ;
                end
`else
                state_d = READ;
`endif
            end
            ALIGN: begin
                state_d = READ;
            end
            READ: begin
                data_d  = bus_rdata;
                state_d = WRITE;
            end
            WRITE: begin
                // index wraps inside the page; the page byte is never touched
                index_d = index_q + 8'd1;
                if (index_q == 8'hFF) begin
                    state_d = IDLE;
                end else begin
                    state_d = READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        halt_d = (state_d != IDLE);
        busy_d = (state_d != IDLE);
    end

    // State and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            page_q   <= 8'h00;
            index_q  <= 8'h00;
            data_q   <= 8'h00;
            parity_q <= 1'b0;
            halt_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            index_q  <= index_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            halt_q   <= halt_d;
            busy_q   <= busy_d;
        end
    end

    // Bus mux: CPU pass-through in IDLE, DMA-owned otherwise
    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_we    = cpu_we;
        case (state_q)
            IDLE: begin
                bus_addr  = cpu_addr;
                bus_wdata = cpu_wdata;
                bus_we    = cpu_we;
            end
            HALT, ALIGN: begin
                bus_addr  = {page_q, 8'h00};
                bus_wdata = 8'h00;
                bus_we    = 1'b0;
            end
            READ: begin
                bus_addr  = {page_q, index_q};
                bus_wdata = 8'h00;
                bus_we    = 1'b0;
            end
            WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_wdata = data_q;
                bus_we    = 1'b1;
            end
            default: begin
                bus_addr  = cpu_addr;
                bus_wdata = cpu_wdata;
                bus_we    = cpu_we;
            end
        endcase
    end

    assign cpu_halt = halt_q;
    assign dma_busy = busy_q;

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, meaning CPU write address that triggers a DMA.
REQ-002 SHALL have parameter OAM_DATA_ADDR, default 16'h2004, meaning PPU OAM data register that receives every DMA write.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_addr  input  16  CPU bus address.
REQ-006 SHALL have port cpu_wdata  input  8  CPU write data.
REQ-007 SHALL have port cpu_we  input  1  CPU write strobe.
REQ-008 SHALL have port bus_rdata  input  8  read data returned by the memory/register fabric for bus_addr.
REQ-009 SHALL have port bus_addr  output  16  address driven to the CPU address decoder.
REQ-010 SHALL have port bus_wdata  output  8  write data to the fabric.
REQ-011 SHALL have port bus_we  output  1  write strobe to the fabric.
REQ-012 SHALL have port cpu_halt  output  1  stalls the CPU while high.
REQ-013 SHALL have port dma_busy  output  1  high while a transfer owns the bus.

Function
REQ-014 SHALL use states IDLE, HALT, ALIGN, READ and WRITE.
REQ-015 In IDLE: bus_addr=cpu_addr, bus_wdata=cpu_wdata, bus_we=cpu_we, combinationally (zero latency).
REQ-016 In IDLE, a cycle with cpu_we=1 and cpu_addr==DMA_REG_ADDR SHALL latch page=cpu_wdata, clear the 8-bit index, and move to HALT; the triggering write also passes through to the bus.
REQ-017 cpu_halt and dma_busy SHALL be registered, asserted from the first HALT cycle, and deasserted on the cycle after the final WRITE.
REQ-018 In HALT, ALIGN, READ and WRITE, the CPU inputs SHALL be ignored (writes to DMA_REG_ADDR included), and the bus SHALL be driven only by the DMA.
REQ-019 HALT lasts exactly one cycle with bus_we=0 and bus_addr={page,8'h00}; it then goes to ALIGN or READ per REQ-026.
REQ-020 ALIGN lasts exactly one cycle with bus_we=0 and bus_addr={page,8'h00}, then goes to READ.
REQ-021 READ: bus_addr={page,index}, bus_we=0; bus_rdata SHALL be captured into an 8-bit data latch on the clock edge ending READ; next state WRITE.
REQ-022 WRITE: bus_addr=OAM_DATA_ADDR, bus_wdata=data latch, bus_we=1.
REQ-023 On the edge ending WRITE, the index SHALL increment modulo 256. If the index was 8'hFF, the next state is IDLE; otherwise READ.
REQ-024 Each transfer SHALL perform exactly 256 READ/WRITE pairs, with source addresses {page,00} through {page,FF} in ascending order; the index never carries into page.
REQ-025 A 1-bit parity register SHALL toggle every clock from reset, regardless of state.

Reset
REQ-027 While rst_n=0: state=IDLE, cpu_halt=0, dma_busy=0, index=0, page=0, data latch=0, parity=0, so the bus is in CPU pass-through.
REQ-028 rst_n asserted mid-transfer SHALL abort immediately, with no further DMA bus writes; after deassertion the block SHALL wait for a new trigger.

Configuration
REQ-026 With macro OAM_DMA_ODD_ALIGN_EN defined, HALT SHALL go to ALIGN when parity=1 during HALT and to READ otherwise (514 or 513 halted cycles); without it, HALT SHALL always go to READ, ALIGN SHALL be unreachable, and halted length is always 513 cycles.

Verification
REQ-029 Reset, then CPU writes 8'h02 to 16'h4014 with parity=0 in the following cycle: cpu_halt high for 513 cycles; bus reads 16'h0200..16'h02FF, each followed by a write to 16'h2004 with the read value.
REQ-030 With OAM_DMA_ODD_ALIGN_EN defined, trigger so that parity=1 in HALT: exactly one ALIGN cycle; cpu_halt high for 514 cycles; first READ at 16'h0200.
REQ-031 Page 8'hFF transfer: last read at 16'hFFFF; next read never 16'h0000; the block returns to IDLE and bus_addr follows cpu_addr the cycle after cpu_halt falls.
REQ-032 During a transfer, drive cpu_we=1 with cpu_addr=16'h4014 and cpu_wdata=8'h07: the page stays at its original value, the transfer stays 256 pairs, and no bus write reaches 16'h4014.
REQ-033 Pull rst_n low at index 8'h80 in WRITE: cpu_halt=0 and bus_we=cpu_we at once; no further 16'h2004 writes; a later trigger with 8'h03 starts cleanly at 16'h0300.
REQ-034 In IDLE, a write of 8'h55 to 16'h2004 appears unchanged on the bus in the same cycle, and no DMA starts.
